// File: rtl/psum_wb.sv
// psum_wb: drains OFIFO psum words into psum memory at base + kij*nij_len + nij.
// Latency: each write appears on the memory port one cycle after its OFIFO pop. Sustains one write per cycle.
// Backpressure: there is no pop while stall is high or the OFIFO is empty. Optional err flag under `define PSUM_WB_ERR_EN.
module psum_wb #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int nij_len = 3,
    parameter int kij_len = 9,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic                     stall,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic                     mem_cen_n,
    output logic                     mem_wen_n,
    output logic [addr_bw-1:0]       mem_addr,
    output logic [col*psum_bw-1:0]   mem_din,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int W  = col * psum_bw;
    localparam int NW = (nij_len > 1) ? $clog2(nij_len) : 1;
    localparam int KW = $clog2(kij_len + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [addr_bw-1:0] r_base;
    logic [addr_bw-1:0] r_addr;
    logic [addr_bw-1:0] w_addr;
    logic [NW-1:0]      r_nij;
    logic [KW-1:0]      r_kij;
    logic [W-1:0]       r_din;
    logic               r_wr;
    logic               w_pop;
    logic               w_start;
    logic               w_nij_last;
    logic               w_job_last;

    assign w_start    = (r_state == S_IDLE) && start;
    assign w_pop      = ofifo_valid && (r_state == S_RUN) && !stall;
    assign w_nij_last = (r_nij == NW'(nij_len - 1));
    assign w_job_last = w_nij_last && (r_kij == KW'(kij_len - 1));
    // Address arithmetic is done in addr_bw bits, so it wraps modulo 2^addr_bw.
    assign w_addr     = r_base + addr_bw'(r_kij) * addr_bw'(nij_len) + addr_bw'(r_nij);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic. The final pop goes to FLUSH so that its write can drain.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_pop && w_job_last) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode. The memory strobes follow the registered write flag.
    always_comb begin
        ofifo_rd  = w_pop;
        busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
        done      = (r_state == S_DONE);
        mem_cen_n = ~r_wr;
        mem_wen_n = ~r_wr;
        mem_addr  = r_addr;
        mem_din   = r_din;
    end

    // Job counters: the base is latched on start, and nij wraps into kij on each pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base <= '0;
            r_nij  <= '0;
            r_kij  <= '0;
        end else if (w_start) begin
            r_base <= base_addr;
            r_nij  <= '0;
            r_kij  <= '0;
        end else if (w_pop) begin
            if (w_nij_last) begin
                r_nij <= '0;
                r_kij <= r_kij + 1'b1;
            end else begin
                r_nij <= r_nij + 1'b1;
            end
        end
    end

    // Write stage: capture the popped word and its address, then strobe the memory for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            r_wr <= w_pop;
            if (w_pop) begin
                r_addr <= w_addr;
                r_din  <= ofifo_out;
            end
        end
    end

`ifdef PSUM_WB_ERR_EN
    logic r_err;

    // Sticky error flag: data is offered while no job is accepting it. A new job clears the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                                           r_err <= 1'b0;
        else if (w_start)                                                     r_err <= 1'b0;
        else if (ofifo_valid && ((r_state == S_IDLE) || (r_state == S_DONE))) r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_psum_wb.sv
// tb_psum_wb: drives random OFIFO words and stall patterns into psum_wb.
// A scoreboard of expected (address, data) writes is built from the job rules: address = base + word index, modulo 2^11.
// The bench also checks reset, done timing, stall behaviour and the err flag.
module tb_psum_wb;

    localparam int COL  = 8;
    localparam int PBW  = 16;
    localparam int W    = COL * PBW;
    localparam int AW   = 11;
    localparam int NIJ  = 3;
    localparam int KIJ  = 9;
    localparam int NJOB = NIJ * KIJ;
`ifdef PSUM_WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          stall;
    logic          ofifo_valid;
    logic [W-1:0]  ofifo_out;
    logic          ofifo_rd;
    logic          mem_cen_n;
    logic          mem_wen_n;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_din;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    psum_wb #(
        .col(COL), .psum_bw(PBW), .nij_len(NIJ), .kij_len(KIJ), .addr_bw(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .stall(stall), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
        .ofifo_rd(ofifo_rd), .mem_cen_n(mem_cen_n), .mem_wen_n(mem_wen_n),
        .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0]  fq[$];
    logic [AW-1:0] ea[$];
    logic [W-1:0]  ed[$];
    bit            feed;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive_fifo();
        ofifo_valid = feed && (fq.size() > 0);
        ofifo_out   = (fq.size() > 0) ? fq[0] : '0;
    endtask

    // Runs one job. smode 0 = no stall, 1 = alternating stall, 2 = random stall.
    // restart_at >= 0 pulses start again after that many pops. rst_after > 0 resets after that many pops.
    task automatic run_job(input logic [AW-1:0] base, input int smode, input int restart_at, input int rst_after);
        int            pops;
        int            widx;
        int            first_wc;
        int            last_wc;
        bit            pop_now;
        bit            done_seen;
        bit            aborted;
        logic [W-1:0]  w;
        logic [AW-1:0] a;
        pops = 0; widx = 0; first_wc = -1; last_wc = -1;
        done_seen = 1'b0; aborted = 1'b0;
        fq.delete(); ea.delete(); ed.delete();
        for (int i = 0; i < NJOB; i++) begin
            w = rand_word();
            a = base + AW'(i);
            fq.push_back(w);
            ea.push_back(a);
            ed.push_back(w);
        end
        @(posedge clk); #1;
        base_addr = base; start = 1'b1; feed = 1'b0; stall = 1'b0; drive_fifo();
        @(posedge clk); #1;
        start = 1'b0; base_addr = ~base; feed = 1'b1; drive_fifo();
        chk("busy_after_start", busy, 1);
        for (int cyc = 0; cyc < 400 && !done_seen && !aborted; cyc++) begin
            @(negedge clk);
            pop_now = ofifo_rd;
            if (stall) chk("no_pop_in_stall", ofifo_rd, 0);
            if (!mem_wen_n) begin
                if (widx < NJOB) begin
                    chk("wr_addr", mem_addr, ea[widx]);
                    chk("wr_data", mem_din, ed[widx]);
                    chk("wr_cen", mem_cen_n, 0);
                end else begin
                    chk("write_count", widx + 1, NJOB);
                end
                if (first_wc < 0) first_wc = cyc;
                last_wc = cyc;
                widx++;
                if (widx == NJOB) chk("busy_in_flush", busy, 1);
            end
            if (done) begin
                chk("done_after_flush", cyc, last_wc + 1);
                chk("writes_before_done", widx, NJOB);
                done_seen = 1'b1;
            end
            @(posedge clk); #1;
            if (pop_now) begin
                void'(fq.pop_front());
                pops++;
            end
            if (rst_after > 0 && pop_now && pops == rst_after) begin
                reset = 1'b0;
                #1;
                chk("rst_wen", mem_wen_n, 1);
                chk("rst_cen", mem_cen_n, 1);
                chk("rst_busy", busy, 0);
                chk("rst_rd", ofifo_rd, 0);
                chk("rst_addr", mem_addr, 0);
                chk("rst_din", mem_din, 0);
                chk("writes_before_rst", widx, rst_after - 1);
                feed = 1'b0; fq.delete(); drive_fifo();
                @(negedge clk);
                chk("rst_no_write", mem_wen_n, 1);
                reset = 1'b1;
                aborted = 1'b1;
            end else begin
                start = (pops == restart_at) && pop_now;
                if (start) base_addr = base + 11'd300;
                if (smode == 1)      stall = ~stall;
                else if (smode == 2) stall = ($urandom_range(0, 2) == 0);
                else                 stall = 1'b0;
                drive_fifo();
            end
        end
        if (!aborted) begin
            chk("job_done_seen", done_seen, 1);
            if (smode == 0) chk("back_to_back", last_wc - first_wc, NJOB - 1);
            @(negedge clk);
            a = base + AW'(NJOB - 1);
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
            chk("addr_hold", mem_addr, a);
            chk("wen_idle", mem_wen_n, 1);
            chk("err_clean", err, 0);
        end
        feed = 1'b0; stall = 1'b0; start = 1'b0; drive_fifo();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; stall = 1'b0;
        feed = 1'b0; ofifo_valid = 1'b0; ofifo_out = '0;
        #12;
        chk("reset_cen", mem_cen_n, 1);
        chk("reset_wen", mem_wen_n, 1);
        chk("reset_addr", mem_addr, 0);
        chk("reset_din", mem_din, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd", ofifo_rd, 0);
        chk("reset_err", err, 0);
        @(negedge clk);
        reset = 1'b1;

        run_job(11'd0,    0, -1, 0);
        run_job(11'd100,  1, -1, 0);
        run_job(11'd2040, 0, -1, 0);
        run_job(11'd50,   0, -1, 10);
        run_job(11'd7,    0, -1, 0);
        run_job(11'd400,  0, 5,  0);
        run_job(AW'($urandom_range(0, 2047)), 2, -1, 0);

        // Data is offered while idle. The err flag is sticky until the next start.
        @(posedge clk); #1;
        ofifo_valid = 1'b1; ofifo_out = rand_word();
        @(negedge clk);
        chk("idle_no_pop", ofifo_rd, 0);
        chk("err_before_edge", err, 0);
        @(posedge clk); #1;
        chk("err_set", err, ERR_EN);
        ofifo_valid = 1'b0;
        @(posedge clk); #1;
        chk("err_sticky", err, ERR_EN);
        start = 1'b1; base_addr = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_cleared", err, 0);
        chk("err_job_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("err_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
